ni_inject_queue: RTL and testbench

Network-interface injection queue for one NoC node. It sits directly downstream of that node's `dataout_buf` traffic source and upstream of the router's local input port. It absorbs the source's free-running 20-bit word stream, which has no backpressure, and filters out null and mis-sourced words. Surviving flits are buffered in a FIFO and presented to the router over a valid/ready handshake, with overflow and filter counters.

---
 rtl/noc_flit_pkg.sv | 27 ++
 rtl/ni_fifo_core.sv | 75 +++++++
 rtl/ni_inject_queue.sv | 83 ++++++++
 tb/tb_ni_inject_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : noc_flit_pkg
// Brief   : Flit format shared by dataout_buf, the NI injection queue and router.
// Revision: 1.0
// ============================================================================
package noc_flit_pkg;

    localparam int FLIT_W      = 20;
    localparam int SRC_LSB     = 12;
    localparam int SRC_MSB     = 15;
    localparam int DEST_LSB    = 4;
    localparam int DEST_MSB    = 7;
    localparam int PAYLOAD_LSB = 0;
    localparam int PAYLOAD_MSB = 3;

    typedef logic [FLIT_W-1:0] flit_t;

    localparam flit_t NULL_FLIT = 20'h00000;

    function automatic logic [3:0] flit_src(input flit_t f);
        return f[SRC_MSB:SRC_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ni_fifo_core.sv
`default_nettype none
// ============================================================================
// Module  : ni_fifo_core
// Brief   : FWFT flit FIFO; a full queue still accepts a push when it pops.
// Revision: 1.0
// ============================================================================
module ni_fifo_core
    import noc_flit_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_cand,
    input  flit_t                    wr_data,
    input  logic                     rd_ready,
    output flit_t                    rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);

    flit_t                r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_fill;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full   = (r_fill == c_FULL);
    assign w_empty  = (r_fill == '0);
    assign w_pop    = !w_empty && rd_ready;
    assign w_push   = push_cand && (!w_full || w_pop);
    assign overflow = push_cand && w_full && !w_pop;

    assign rd_valid = !w_empty;
    assign fill     = r_fill;
    // Gated so the output reads zero out of reset even though storage is not reset.
    assign rd_data  = w_empty ? NULL_FLIT : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ni_inject_queue.sv
`default_nettype none
// ============================================================================
// Module  : ni_inject_queue
// Brief   : NI injection queue: filters null/mis-sourced words, buffers flits.
// Revision: 1.0
// ============================================================================
module ni_inject_queue
    import noc_flit_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int NODE_ID = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic [FLIT_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [7:0]               drop_count,
    output logic [7:0]               null_count,
    output logic                     src_err
);

    localparam logic [3:0] c_NODE = 4'(NODE_ID);

    logic       w_is_null;
    logic       w_src_ok;
    logic       w_null_evt;
    logic       w_src_evt;
    logic       w_cand;
    logic       w_overflow;

    logic [7:0] r_drop_count;
    logic [7:0] r_null_count;
    logic       r_src_err;

    assign w_is_null  = (in_data == NULL_FLIT);
    assign w_src_ok   = (flit_src(in_data) == c_NODE);
    assign w_null_evt = in_valid && w_is_null;
    assign w_src_evt  = in_valid && !w_is_null && !w_src_ok;
    assign w_cand     = in_valid && !w_is_null && w_src_ok;

    ni_fifo_core #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_cand (w_cand),
        .wr_data   (in_data),
        .rd_ready  (out_ready),
        .rd_data   (out_data),
        .rd_valid  (out_valid),
        .fill      (fill),
        .overflow  (w_overflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_count <= '0;
            r_null_count <= '0;
            r_src_err    <= 1'b0;
        end else begin
            if (w_overflow && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            if (w_null_evt && (r_null_count != 8'hFF)) begin
                r_null_count <= r_null_count + 8'd1;
            end
            if (w_src_evt) begin
                r_src_err <= 1'b1;
            end
        end
    end

    assign drop_count = r_drop_count;
    assign null_count = r_null_count;
    assign src_err    = r_src_err;

endmodule

`default_nettype wire

// File: tb/tb_ni_inject_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_ni_inject_queue
// Brief   : Directed + random bench for ni_inject_queue against a queue model.
// Revision: 1.0
// ============================================================================
module tb_ni_inject_queue;

    localparam int DEPTH   = 16;
    localparam int NODE_ID = 14;

    logic        clk;
    logic        rst;
    logic [19:0] in_data;
    logic        in_valid;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fill;
    logic [7:0]  drop_count;
    logic [7:0]  null_count;
    logic        src_err;

    int checks   = 0;
    int failures = 0;

    logic [19:0] mq[$];
    int          m_drop;
    int          m_null;
    logic        m_src_err;

    ni_inject_queue #(
        .DEPTH   (DEPTH),
        .NODE_ID (NODE_ID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill       (fill),
        .drop_count (drop_count),
        .null_count (null_count),
        .src_err    (src_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, ".fill"},      32'(fill),      32'(mq.size()));
        chk({tag, ".drop"},      32'(drop_count), 32'(m_drop));
        chk({tag, ".null"},      32'(null_count), 32'(m_null));
        chk({tag, ".src_err"},   32'(src_err),   32'(m_src_err));
        if (mq.size() > 0) begin
            chk({tag, ".out_data"}, 32'(out_data), 32'(mq[0]));
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_drop    = 0;
        m_null    = 0;
        m_src_err = 1'b0;
    endtask

    // One clock: drive inputs, advance, apply the queue rules, compare.
    task automatic step(input string tag, input logic v, input logic [19:0] d, input logic rdy);
        bit do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        do_pop    = (mq.size() > 0) && rdy;
        @(posedge clk);
        #1;
        if (do_pop) void'(mq.pop_front());
        if (v) begin
            if (d == 20'h0) begin
                if (m_null < 255) m_null++;
            end else if (d[15:12] != 4'(NODE_ID)) begin
                m_src_err = 1'b1;
            end else if (mq.size() < DEPTH) begin
                mq.push_back(d);
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        check_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic mid_reset(input string tag);
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        check_all(tag);
        chk({tag, ".out_data_zero"}, 32'(out_data), 32'h0);
        #2;
        rst = 1'b1;
    endtask

    function automatic logic [19:0] good_flit();
        logic [19:0] f;
        f = 20'($urandom());
        f[15:12] = 4'(NODE_ID);
        return f;
    endfunction

    initial begin
        logic [19:0] f;
        int          r;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 20'h0;
        out_ready = 1'b0;
        model_clear();
        #2;
        check_all("reset");
        chk("reset.out_data", 32'(out_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic path at full rate
        step("basic0", 1'b1, 20'h0E000, 1'b1);
        step("basic1", 1'b1, 20'h0E011, 1'b1);
        step("basic2", 1'b1, 20'h0E022, 1'b1);
        step("basic3", 1'b0, 20'h0,     1'b1);

        // Null filtering
        for (int i = 0; i < 15; i++) step("nf_good", 1'b1, {4'h0, 4'hE, 4'h0, 8'(i + 8'h40)}, 1'b1);
        for (int i = 0; i < 15; i++) step("nf_null", 1'b1, 20'h0, 1'b1);
        chk("nf.null_count15", 32'(null_count), 32'd15);

        // Overflow, then full with simultaneous push/pop, then drain across wrap
        for (int i = 0; i < 20; i++) step("ovf", 1'b1, {4'h3, 4'hE, 4'h5, 8'(i)}, 1'b0);
        chk("ovf.fill16", 32'(fill), 32'd16);
        chk("ovf.drop4",  32'(drop_count), 32'd4);
        step("full_pp", 1'b1, 20'h9E7AB, 1'b1);
        for (int i = 0; i < 17; i++) step("drain", 1'b0, 20'h0, 1'b1);

        // Source mismatch stays sticky through good traffic
        step("srcmis", 1'b1, 20'h0A055, 1'b1);
        for (int i = 0; i < 4; i++) step("srcmis_good", 1'b1, good_flit(), 1'b1);

        // Random mix
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       f = 20'h0;
            else if (r == 2) begin
                f = 20'($urandom());
                f[15:12] = 4'($urandom_range(0, 13));
                if (f == 20'h0) f = 20'h00001;
            end else         f = good_flit();
            step("rand", ($urandom_range(0, 9) < 8), f, ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 20; i++) step("rand_drain", 1'b0, 20'h0, 1'b1);

        // Counter saturation
        for (int i = 0; i < 260; i++) step("null_sat", 1'b1, 20'h0, 1'b0);
        chk("null_sat.255", 32'(null_count), 32'd255);
        for (int i = 0; i < 275; i++) step("drop_sat", 1'b1, good_flit(), 1'b0);
        chk("drop_sat.255", 32'(drop_count), 32'd255);

        mid_reset("rst1");
        step("rst1_push", 1'b1, 20'h1E234, 1'b0);
        step("rst1_idle", 1'b0, 20'h0, 1'b1);

        // Reach fill=7, drop=3 then reset mid-stream
        for (int i = 0; i < 19; i++) step("prep", 1'b1, good_flit(), 1'b0);
        for (int i = 0; i < 9; i++) step("prep_pop", 1'b0, 20'h0, 1'b1);
        chk("prep.fill7", 32'(fill), 32'd7);
        chk("prep.drop3", 32'(drop_count), 32'd3);
        in_valid  = 1'b1;
        in_data   = 20'h0AAAA;
        mid_reset("rst2");
        step("rst2_push", 1'b1, 20'h0E5C3, 1'b0);
        chk("rst2.out_data", 32'(out_data), 32'h0E5C3);
        step("rst2_pop", 1'b0, 20'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
